tune_step_controller: RTL and testbench
=======================================

// Module: tune_step_controller
// PURPOSE
//  Turns up/down detent pulses from the rotary encoder front end into a clamped tuning word.
//  Button-selectable step size. Pending-detent buffering. Valid/ready handshake to the
//  LO/DDS configuration path.
//  Sits between the encoder decoder (i_up/i_down single-cycle pulses) and the synth programmer.
// PARAMETERS
//  FREQ_W       32          width of tuning word
//  F_MIN        0           lower clamp (inclusive)
//  F_MAX        2**32-1     upper clamp (inclusive); F_MIN <= F_RESET <= F_MAX
//  F_RESET      0           tuning word after reset
//  ACCEL_WINDOW 2_000_000   cycles; detents closer than this are accelerated (ACCEL_EN only)
//  ACCEL_MULT   10          step multiplier when accelerated (ACCEL_EN only)
// PORTS
//  i_clk        in   1       system clock
//  i_rst        in   1       asynchronous, active-high reset
//  i_up         in   1       1-cycle pulse: one detent clockwise
//  i_down       in   1       1-cycle pulse: one detent anticlockwise
//  i_step_btn   in   1       1-cycle pulse (debounced upstream): advance step size
//  o_freq       out  FREQ_W  current tuning word
//  o_step_idx   out  2       selected step index into step table
//  o_valid      out  1       o_freq holds a new value not yet accepted
//  i_ready      in   1       downstream accepts o_freq when o_valid & i_ready
// BEHAVIOUR
//  Reset (async, immediate): o_freq=F_RESET, o_step_idx=0, o_valid=0.
//   Also: state=IDLE, pending=0, accel counter=ACCEL_WINDOW.
//  Step table (package): idx0=1, idx1=10, idx2=100, idx3=1000.
//  i_step_btn: o_step_idx increments, 3 wraps to 0; honoured in any state.
//   In the same cycle as an update, the update uses the old step.
//  pending: 4-bit signed net detent count.
//   i_up +1, i_down -1, both in same cycle = 0.
//   Saturates at +7/-8; excess detents are dropped.
//  State IDLE: dir = sign(pending) if pending!=0, else sign(i_up - i_down).
//   If dir!=0 compute new word; the consumed detent is removed from pending.
//   A fresh pulse in the same cycle as draining pending is added to pending.
//   Up:   sum in FREQ_W+1 bits; if > F_MAX -> F_MAX.
//   Down: if freq < F_MIN + step -> F_MIN (no wrap/borrow).
//   new != o_freq: o_freq<=new, o_valid<=1, ->PEND. Latency: pulse cycle N -> o_freq/o_valid at N+1.
//   new == o_freq (at limit): detent discarded, no handshake, stay IDLE.
//  State PEND: o_freq, o_valid stable. Detents only accumulate into pending.
//   o_valid & i_ready: o_valid<=0 next cycle, ->IDLE.
//   Next update no earlier than 1 cycle after acceptance.
//  i_ready while o_valid=0 is ignored.
//  Reset mid-PEND: transfer abandoned, pending lost.
// CONFIGURATION
//  Macro TUNE_STEP_ACCEL_EN.
//  Defined: free-running counter, cleared on every applied detent, saturates at ACCEL_WINDOW.
//   Applied detent with counter < ACCEL_WINDOW uses step*ACCEL_MULT; same clamp rules apply.
//   The product is computed at FREQ_W+1 bits; a product > F_MAX is treated as overflow -> clamp.
//  Undefined: no counter logic; step is always the table value.
// STRUCTURE
//  Package tune_ctrl_pkg: step table constants, STEP_IDX_W=2, state encoding (IDLE, PEND),
//   PEND_W=4 with saturation limits.
//  Sub-module tune_freq_clamp (combinational): freq, step, dir, F_MIN/F_MAX -> clamped new
//   word plus changed flag.
//  Top holds the FSM, pending counter, step index, accel counter and handshake registers.
// TESTING
//  1 Reset, idx0, i_up x3, i_ready=1 -> o_freq F_RESET+1,+2,+3; o_valid 1 cycle each, 1 cycle after pulse.
//  2 i_step_btn x2 (idx2), F_RESET=F_MAX-150, i_up x2 -> F_MAX-50 then F_MAX;
//    third i_up -> no o_valid.
//    Mirror at F_MIN with i_down: no wrap.
//  3 i_ready=0 after first update, 10 i_up pulses -> pending saturates +7;
//    o_freq held through PEND.
//    Raise i_ready -> exactly 7 further updates, one per handshake.
//  4 i_up and i_down same cycle in IDLE -> no update.
//    i_step_btn coincident with i_up at idx0 -> step 1 used, idx becomes 1.
//  5 Assert i_rst while o_valid=1 -> o_valid, o_freq, o_step_idx reset same cycle, pending cleared.
//  6 TUNE_STEP_ACCEL_EN, ACCEL_WINDOW=100, ACCEL_MULT=10, idx0: i_up gap 50 -> second step 10.
//    Gap 150 -> step 1. Undefined build: both steps 1.

Source files
------------

// File: rtl/tune_ctrl_pkg.sv
// Shared constants for the tuning-step controller: step table, pending-count limits,
// FSM state and detent-direction encodings.
package tune_ctrl_pkg;

    localparam int STEP_IDX_W = 2;
    localparam int PEND_W     = 4;

    localparam logic signed [PEND_W-1:0] PEND_MAX = 4'sb0111;
    localparam logic signed [PEND_W-1:0] PEND_MIN = 4'sb1000;
    localparam logic signed [PEND_W-1:0] PEND_ONE = 4'sb0001;

    localparam logic [31:0] STEP_0 = 32'd1;
    localparam logic [31:0] STEP_1 = 32'd10;
    localparam logic [31:0] STEP_2 = 32'd100;
    localparam logic [31:0] STEP_3 = 32'd1000;

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    function automatic logic [31:0] step_value(input logic [STEP_IDX_W-1:0] idx);
        logic [31:0] s;
        case (idx)
            2'd0:    s = STEP_0;
            2'd1:    s = STEP_1;
            2'd2:    s = STEP_2;
            default: s = STEP_3;
        endcase
        return s;
    endfunction

    // Saturating +/-1 on the signed pending count; inc and dec together cancel.
    function automatic logic signed [PEND_W-1:0] pend_add(
        input logic signed [PEND_W-1:0] p,
        input logic                     inc,
        input logic                     dec
    );
        logic signed [PEND_W-1:0] r;
        r = p;
        if (inc && !dec && (p != PEND_MAX)) begin
            r = p + PEND_ONE;
        end else if (dec && !inc && (p != PEND_MIN)) begin
            r = p - PEND_ONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/tune_step_controller_if.sv
// Encoder-side detent/button inputs and the tuning-word valid/ready stream.
// master = controller (sources the tuning word), slave = encoder front end plus synth programmer.
interface tune_step_controller_if
    import tune_ctrl_pkg::*;
#(
    parameter int FREQ_W = 32
);
    logic                  i_up;
    logic                  i_down;
    logic                  i_step_btn;
    logic [FREQ_W-1:0]     o_freq;
    logic [STEP_IDX_W-1:0] o_step_idx;
    logic                  o_valid;
    logic                  i_ready;

    modport master (
        input  i_up, i_down, i_step_btn, i_ready,
        output o_freq, o_step_idx, o_valid
    );

    modport slave (
        output i_up, i_down, i_step_btn, i_ready,
        input  o_freq, o_step_idx, o_valid
    );
endinterface

// File: rtl/tune_freq_clamp.sv
// Combinational one-detent tuning-word update clamped to [F_MIN, F_MAX], plus a changed flag.
// Up-sum is carried one bit wider; down never borrows below F_MIN.
module tune_freq_clamp
    import tune_ctrl_pkg::*;
#(
    parameter int                FREQ_W = 32,
    parameter logic [FREQ_W-1:0] F_MIN  = '0,
    parameter logic [FREQ_W-1:0] F_MAX  = '1
) (
    input  logic [FREQ_W-1:0] freq,
    input  logic [FREQ_W:0]   step,
    input  dir_t              dir,
    output logic [FREQ_W-1:0] new_freq,
    output logic              changed
);
    logic [FREQ_W:0]   up_sum;
    logic [FREQ_W+1:0] down_floor;

    always_comb begin
        up_sum     = {1'b0, freq} + step;
        down_floor = {2'b00, F_MIN} + {1'b0, step};
        new_freq   = freq;
        case (dir)
            DIR_UP: begin
                new_freq = (up_sum > {1'b0, F_MAX}) ? F_MAX : up_sum[FREQ_W-1:0];
            end
            DIR_DOWN: begin
                new_freq = ({2'b00, freq} < down_floor) ? F_MIN : (freq - step[FREQ_W-1:0]);
            end
            default: begin
                new_freq = freq;
            end
        endcase
        changed = (new_freq != freq);
    end

endmodule

// File: rtl/tune_step_controller.sv
// Detent pulses -> clamped tuning word with valid/ready hand-off; update visible one cycle after the pulse,
// detents arriving while a word awaits acceptance are buffered (+7/-8). Acceleration under TUNE_STEP_ACCEL_EN.
module tune_step_controller
    import tune_ctrl_pkg::*;
#(
    parameter int                FREQ_W       = 32,
    parameter logic [FREQ_W-1:0] F_MIN        = '0,
    parameter logic [FREQ_W-1:0] F_MAX        = '1,
    parameter logic [FREQ_W-1:0] F_RESET      = '0,
    parameter int unsigned       ACCEL_WINDOW = 2_000_000,
    parameter int unsigned       ACCEL_MULT   = 10
) (
    input logic                   i_clk,
    input logic                   i_rst,
    tune_step_controller_if.master bus
);
    localparam int W1 = FREQ_W + 1;

    state_t                   state_q, state_d;
    logic [FREQ_W-1:0]        freq_q, freq_d;
    logic [STEP_IDX_W-1:0]    idx_q, idx_d;
    logic                     valid_q, valid_d;
    logic signed [PEND_W-1:0] pend_q, pend_d;

    dir_t              dir;
    logic              applied;
    logic [W1-1:0]     step_base;
    logic [W1-1:0]     step_use;
    logic [FREQ_W-1:0] new_freq;
    logic              changed;

    // Buffered detents take priority over a fresh pulse; the fresh one is then queued.
    always_comb begin
        dir = DIR_NONE;
        if (state_q == ST_IDLE) begin
            if (pend_q != '0) begin
                dir = pend_q[PEND_W-1] ? DIR_DOWN : DIR_UP;
            end else if (bus.i_up && !bus.i_down) begin
                dir = DIR_UP;
            end else if (bus.i_down && !bus.i_up) begin
                dir = DIR_DOWN;
            end
        end
    end

    assign applied   = (dir != DIR_NONE);
    assign step_base = W1'(step_value(idx_q));

`ifdef TUNE_STEP_ACCEL_EN
    localparam int              CNT_W    = (ACCEL_WINDOW < 2) ? 1 : $clog2(ACCEL_WINDOW + 1);
    localparam int              WX       = 2 * W1;
    localparam logic [CNT_W-1:0] ACNT_SAT = CNT_W'(ACCEL_WINDOW);

    logic [CNT_W-1:0] acnt_q, acnt_d;
    logic [WX-1:0]    prod;

    // An oversized product is forced to F_MAX+1 so both directions clamp.
    always_comb begin
        acnt_d = acnt_q;
        if (applied) begin
            acnt_d = '0;
        end else if (acnt_q != ACNT_SAT) begin
            acnt_d = acnt_q + CNT_W'(1);
        end
        prod     = {{W1{1'b0}}, step_base} * WX'(ACCEL_MULT);
        step_use = step_base;
        if (acnt_q < ACNT_SAT) begin
            step_use = (prod > WX'(F_MAX)) ? (W1'(F_MAX) + W1'(1)) : prod[W1-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acnt_q <= ACNT_SAT;
        end else begin
            acnt_q <= acnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (ACCEL_WINDOW == 0) ^ (ACCEL_MULT == 0);
    assign step_use   = step_base;
`endif

    tune_freq_clamp #(
        .FREQ_W (FREQ_W),
        .F_MIN  (F_MIN),
        .F_MAX  (F_MAX)
    ) u_clamp (
        .freq     (freq_q),
        .step     (step_use),
        .dir      (dir),
        .new_freq (new_freq),
        .changed  (changed)
    );

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        idx_d   = bus.i_step_btn ? (idx_q + STEP_IDX_W'(1)) : idx_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q != '0) begin
                    pend_d = pend_add(pend_add(pend_q, pend_q[PEND_W-1], !pend_q[PEND_W-1]),
                                      bus.i_up, bus.i_down);
                end
                // A detent that would not move the word (at a limit) is simply dropped.
                if (applied && changed) begin
                    freq_d  = new_freq;
                    valid_d = 1'b1;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                pend_d = pend_add(pend_q, bus.i_up, bus.i_down);
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            freq_q  <= F_RESET;
            idx_q   <= '0;
            valid_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.o_freq     = freq_q;
    assign bus.o_step_idx = idx_q;
    assign bus.o_valid    = valid_q;

endmodule

// File: tb/tb_tune_step_controller.sv
// Scoreboard bench for tune_step_controller: expected words queued at detent time, checked on each handshake.
module tb_tune_step_controller;
    localparam int          FREQ_W  = 16;
    localparam int unsigned F_MIN   = 100;
    localparam int unsigned F_MAX   = 60050;
    localparam int unsigned F_RESET = 59900;
`ifdef TUNE_STEP_ACCEL_EN
    localparam int ACC = 10;
`else
    localparam int ACC = 1;
`endif
    localparam int SLOW = 120;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tune_step_controller_if #(.FREQ_W(FREQ_W)) bus ();

    tune_step_controller #(
        .FREQ_W       (FREQ_W),
        .F_MIN        (16'(F_MIN)),
        .F_MAX        (16'(F_MAX)),
        .F_RESET      (16'(F_RESET)),
        .ACCEL_WINDOW (100),
        .ACCEL_MULT   (10)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          hs_cnt = 0;
    bit          prev_hs = 1'b0;
    int          steps [4] = '{1, 10, 100, 1000};
    int          freq_m;
    int          idx_m;
    int          sb_q [$];

    task automatic chk_eq(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_next(input int f, input int step, input bit up);
        int r;
        if (up) begin
            r = f + step;
            if (r > int'(F_MAX)) r = int'(F_MAX);
        end else begin
            r = f - step;
            if (r < int'(F_MIN)) r = int'(F_MIN);
        end
        return r;
    endfunction

    // Handshake monitor: sampled just after the falling edge, well clear of the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (prev_hs) chk_eq("post_accept_gap", bus.o_valid, 0);
                prev_hs = 1'b0;
                if (bus.o_valid && bus.i_ready) begin
                    hs_cnt++;
                    prev_hs = 1'b1;
                    if (sb_q.size() == 0) begin
                        chk_eq("unexpected_update", sb_q.size(), 1);
                    end else begin
                        chk_eq("freq", bus.o_freq, sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        bus.i_up = 1'b0; bus.i_down = 1'b0; bus.i_step_btn = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_eq("rst_valid", bus.o_valid, 0);
        chk_eq("rst_freq", bus.o_freq, F_RESET);
        chk_eq("rst_idx", bus.o_step_idx, 0);
        sb_q.delete();
        freq_m = int'(F_RESET);
        idx_m  = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One detent at the current step times mult; the next stimulus starts gap cycles later (gap >= 2).
    task automatic detent(input bit up, input int mult, input int gap);
        int nf;
        bit chg;
        nf  = model_next(freq_m, steps[idx_m] * mult, up);
        chg = (nf != freq_m);
        if (chg) begin
            sb_q.push_back(nf);
            freq_m = nf;
        end
        bus.i_up = up; bus.i_down = !up;
        @(negedge clk);
        bus.i_up = 1'b0; bus.i_down = 1'b0;
        chk_eq("latency_valid", bus.o_valid, chg);
        @(negedge clk);
        chk_eq("valid_one_cycle", bus.o_valid, chg && !bus.i_ready);
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic press_btn();
        bus.i_step_btn = 1'b1;
        @(negedge clk);
        bus.i_step_btn = 1'b0;
        idx_m = (idx_m + 1) % 4;
        chk_eq("step_idx", bus.o_step_idx, idx_m);
    endtask

    task automatic up_pulse();
        bus.i_up = 1'b1;
        @(negedge clk);
        bus.i_up = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        bus.i_up = 1'b0; bus.i_down = 1'b0; bus.i_step_btn = 1'b0; bus.i_ready = 1'b1;
        freq_m = int'(F_RESET);
        idx_m  = 0;
        repeat (2) @(negedge clk);
        chk_eq("init_freq", bus.o_freq, F_RESET);
        chk_eq("init_valid", bus.o_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic stepping at idx0
        for (int k = 0; k < 3; k++) detent(1'b1, 1, SLOW);
        chk_eq("t1_freq", bus.o_freq, F_RESET + 3);

        // Upper clamp at idx2, then walk down to the lower clamp
        do_reset();
        press_btn();
        press_btn();
        for (int k = 0; k < 3; k++) detent(1'b1, 1, SLOW);
        chk_eq("t2_ceiling", bus.o_freq, F_MAX);
        press_btn();
        for (int k = 0; k < 59; k++) detent(1'b0, 1, SLOW);
        for (int k = 0; k < 3; k++) press_btn();
        for (int k = 0; k < 11; k++) detent(1'b0, 1, SLOW);
        chk_eq("t2_floor", bus.o_freq, F_MIN);

        // Pending saturation under backpressure
        do_reset();
        bus.i_ready = 1'b0;
        detent(1'b1, 1, 2);
        for (int k = 0; k < 10; k++) up_pulse();
        chk_eq("t3_hold_freq", bus.o_freq, F_RESET + 1);
        chk_eq("t3_hold_valid", bus.o_valid, 1);
        repeat (SLOW) @(negedge clk);
        chk_eq("t3_hold_freq2", bus.o_freq, F_RESET + 1);
        for (int k = 0; k < 7; k++) begin
            freq_m = model_next(freq_m, (k == 0) ? 1 : ACC, 1'b1);
            sb_q.push_back(freq_m);
        end
        base = hs_cnt;
        bus.i_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk_eq("t3_handshakes", hs_cnt - base, 8);
        chk_eq("t3_sb_drained", sb_q.size(), 0);
        chk_eq("t3_final_freq", bus.o_freq, freq_m);

        // Cancelling pulses; step button coincident with a detent
        do_reset();
        bus.i_up = 1'b1; bus.i_down = 1'b1;
        @(negedge clk);
        bus.i_up = 1'b0; bus.i_down = 1'b0;
        chk_eq("t4_cancel", bus.o_valid, 0);
        repeat (SLOW) @(negedge clk);
        freq_m = model_next(freq_m, steps[idx_m], 1'b1);
        sb_q.push_back(freq_m);
        bus.i_up = 1'b1; bus.i_step_btn = 1'b1;
        @(negedge clk);
        bus.i_up = 1'b0; bus.i_step_btn = 1'b0;
        idx_m = 1;
        chk_eq("t4_btn_valid", bus.o_valid, 1);
        chk_eq("t4_btn_freq", bus.o_freq, F_RESET + 1);
        chk_eq("t4_btn_idx", bus.o_step_idx, 1);
        repeat (SLOW) @(negedge clk);
        detent(1'b1, 1, SLOW);
        chk_eq("t4_new_step", bus.o_freq, F_RESET + 11);

        // Reset while a word is awaiting acceptance
        do_reset();
        bus.i_ready = 1'b0;
        detent(1'b1, 1, 2);
        for (int k = 0; k < 3; k++) up_pulse();
        press_btn();
        base = hs_cnt;
        do_reset();
        bus.i_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk_eq("t5_pend_cleared", bus.o_freq, F_RESET);
        chk_eq("t5_no_valid", bus.o_valid, 0);
        chk_eq("t5_no_handshake", hs_cnt - base, 0);

        // Acceleration window
        do_reset();
        detent(1'b1, 1, 50);
        detent(1'b1, ACC, 150);
        detent(1'b1, 1, SLOW);
        chk_eq("t6_freq", bus.o_freq, F_RESET + 2 + ACC);

        chk_eq("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
